// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and default constants for the 2x2 convolution sequencer
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILT_RD,
    ST_FILT_LD,
    ST_PRIME,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int DEF_COL_STRIDE  = 15;
  localparam int DEF_ROW_STRIDE  = 135;
  localparam int DEF_FILTER_ADDR = 240;
  localparam int DEF_OUT_BASE    = 384;
  localparam int DEF_OUT_STEP    = 4;
  localparam int DEF_CORE_LAT    = 2;

  // Column counter also times the drain phase, so it must hold 15 and CORE_LAT-1.
  localparam int COL_W = 4;
  localparam int ROW_W = 4;

endpackage

// File: rtl/conv_rd_addr_gen.sv
// rtl/conv_rd_addr_gen.sv - incremental SRAM read-address generator (row base plus column offset)
module conv_rd_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int COL_STRIDE  = DEF_COL_STRIDE,
  parameter int ROW_STRIDE  = DEF_ROW_STRIDE,
  parameter int FILTER_ADDR = DEF_FILTER_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  refresh_i,
  input  logic                  next_col_i,
  input  logic                  next_row_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o
);

  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] col_off_q, col_off_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  // Next row base / column offset; all sums wrap modulo 2^ADDR_WIDTH.
  always_comb begin
    row_base_d = row_base_q;
    col_off_d  = col_off_q;
    if (clear_i) begin
      row_base_d = '0;
      col_off_d  = '0;
    end else if (next_row_i) begin
      row_base_d = row_base_q + ADDR_WIDTH'(ROW_STRIDE);
      col_off_d  = '0;
    end else if (next_col_i) begin
      col_off_d = col_off_q + ADDR_WIDTH'(COL_STRIDE);
    end
  end

  // Clear points the read port at the filter word; other commands present base+offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= '0;
      col_off_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      row_base_q <= row_base_d;
      col_off_q  <= col_off_d;
      if (clear_i)
        rd_addr_q <= ADDR_WIDTH'(FILTER_ADDR);
      else if (refresh_i || next_col_i || next_row_i)
        rd_addr_q <= row_base_d + col_off_d;
    end
  end

  assign rd_addr_o = rd_addr_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - frame sequencer: filter load, column streaming with padding, result write-back
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int COL_STRIDE  = DEF_COL_STRIDE,
  parameter int ROW_STRIDE  = DEF_ROW_STRIDE,
  parameter int NUM_COLS    = 8,
  parameter int NUM_ROWS    = 4,
  parameter int FILTER_ADDR = DEF_FILTER_ADDR,
  parameter int OUT_BASE    = DEF_OUT_BASE,
  parameter int OUT_STEP    = DEF_OUT_STEP,
  parameter int CORE_LAT    = DEF_CORE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  filt_load,
  output logic                  img_shift,
  output logic                  img_pad,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  state_e                state_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic                  busy_q, done_q, rd_en_q, filt_load_q, img_shift_q, img_pad_q;
  logic [CORE_LAT-1:0]   dl_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic cmd_clear, cmd_refresh, cmd_next_col, cmd_next_row, rd_next;
  logic col_at_end, col_next_end, last_row;

  assign col_at_end   = (col_q == COL_W'(NUM_COLS));
  assign col_next_end = (int'(col_q) + 1 == NUM_COLS);
  assign last_row     = (row_q == ROW_W'(NUM_ROWS - 1));

  // Address commands for the read issued next cycle; a read is wanted whenever one is issued.
  always_comb begin
    cmd_clear    = 1'b0;
    cmd_refresh  = 1'b0;
    cmd_next_col = 1'b0;
    cmd_next_row = 1'b0;
    if (!abort) begin
      case (state_q)
        ST_IDLE:    cmd_clear    = start;
        ST_FILT_RD: cmd_refresh  = 1'b1;
        ST_FILT_LD: cmd_next_col = 1'b1;
        ST_PRIME:   cmd_next_col = (2 < NUM_COLS);
        ST_RUN: begin
          if (col_at_end)
            cmd_next_col = !last_row;
          else if (col_next_end)
            cmd_next_row = !last_row;
          else
            cmd_next_col = (int'(col_q) + 2 < NUM_COLS);
        end
        default: ;
      endcase
    end
  end

  assign rd_next = cmd_clear | cmd_refresh | cmd_next_col | cmd_next_row;

  conv_rd_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COL_STRIDE  (COL_STRIDE),
    .ROW_STRIDE  (ROW_STRIDE),
    .FILTER_ADDR (FILTER_ADDR)
  ) u_rd_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (cmd_clear),
    .refresh_i  (cmd_refresh),
    .next_col_i (cmd_next_col),
    .next_row_i (cmd_next_row),
    .rd_addr_o  (rd_addr)
  );

  // Sequencer FSM with registered strobes, write delay line and write-address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      filt_load_q <= 1'b0;
      img_shift_q <= 1'b0;
      img_pad_q   <= 1'b0;
      dl_q        <= '0;
      wr_addr_q   <= ADDR_WIDTH'(OUT_BASE);
    end else if (abort) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      filt_load_q <= 1'b0;
      img_shift_q <= 1'b0;
      img_pad_q   <= 1'b0;
      dl_q        <= '0;
    end else begin
      done_q      <= 1'b0;
      filt_load_q <= 1'b0;
      img_shift_q <= 1'b0;
      img_pad_q   <= 1'b0;
      rd_en_q     <= rd_next;
      // Only RUN-state shifts produce a result; PRIME shifts just fill the window.
      dl_q        <= CORE_LAT'({dl_q, state_q == ST_RUN});
      if (dl_q[CORE_LAT-1])
        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(OUT_STEP);
      case (state_q)
        ST_IDLE: begin
          row_q     <= '0;
          col_q     <= '0;
          wr_addr_q <= ADDR_WIDTH'(OUT_BASE);
          if (start) begin
            state_q <= ST_FILT_RD;
            busy_q  <= 1'b1;
          end
        end
        ST_FILT_RD: begin
          state_q     <= ST_FILT_LD;
          filt_load_q <= 1'b1;
        end
        ST_FILT_LD: begin
          state_q     <= ST_PRIME;
          img_shift_q <= 1'b1;
        end
        ST_PRIME: begin
          state_q     <= ST_RUN;
          col_q       <= COL_W'(1);
          img_shift_q <= 1'b1;
        end
        ST_RUN: begin
          if (col_at_end) begin
            if (last_row) begin
              state_q <= ST_DRAIN;
              col_q   <= '0;
            end else begin
              state_q     <= ST_PRIME;
              row_q       <= row_q + ROW_W'(1);
              img_shift_q <= 1'b1;
            end
          end else begin
            col_q       <= col_q + COL_W'(1);
            img_shift_q <= 1'b1;
            img_pad_q   <= col_next_end;
          end
        end
        ST_DRAIN: begin
          if (col_q == COL_W'(CORE_LAT - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign filt_load = filt_load_q;
  assign img_shift = img_shift_q;
  assign img_pad   = img_pad_q;
  assign wr_en     = dl_q[CORE_LAT-1];
  assign wr_addr   = wr_addr_q;

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for the 2x2 convolution datapath.
- On a start pulse it reads the filter word from SRAM, then streams image columns row by row into the core's shift window, including zero-padding at each row end.
- It writes each core result back to the output region of the SRAM, then pulses done.
- Sits between the ICB CONTROL register (start/abort) and the SRAM read/write ports and image/filter shift registers.

Parameters:
- ADDR_WIDTH, 9: SRAM address width.
- COL_STRIDE, 15: read-address increment per image column.
- ROW_STRIDE, 135: read-address increment per image row.
- NUM_COLS, 8: columns per row (valid range 2..15).
- NUM_ROWS, 4: rows per frame (valid range 1..15).
- FILTER_ADDR, 240: SRAM address of the filter word.
- OUT_BASE, 384: first write address.
- OUT_STEP, 4: write-address increment per result.
- CORE_LAT, 2: cycles from img_shift to valid conv_out (valid range 1..7).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a frame; sampled only in IDLE.
- abort, input, 1: synchronous cancel, effective in any state.
- busy, output, 1: high in every state except IDLE and DONE.
- done, output, 1: one-cycle pulse at frame completion.
- rd_en, output, 1: SRAM read strobe; data is on dout the following cycle.
- rd_addr, output, ADDR_WIDTH: SRAM read address.
- filt_load, output, 1: capture dout into the filter register.
- img_shift, output, 1: shift the image window by one column.
- img_pad, output, 1: qualifies img_shift; load zeros instead of dout.
- wr_en, output, 1: SRAM write strobe for conv_out.
- wr_addr, output, ADDR_WIDTH: SRAM write address.

Behaviour:
- Reset values:
  - busy, done, rd_en, filt_load, img_shift, img_pad and wr_en are 0.
  - rd_addr is 0 and wr_addr is OUT_BASE.
  - State is IDLE and the write delay line is cleared.
- All outputs are registered and the SRAM read latency is 1 cycle.
- States: IDLE, FILT_RD, FILT_LD, PRIME, RUN, DRAIN, DONE.
- IDLE:
  - On start=1 and abort=0, go to FILT_RD.
  - Reload wr_addr to OUT_BASE; clear the row and column counters.
- FILT_RD: rd_en=1, rd_addr=FILTER_ADDR; next state FILT_LD.
- FILT_LD: filt_load=1; rd_en=1, rd_addr=row_base (column 0 of row 0); next state PRIME.
- PRIME:
  - img_shift=1 (column 0).
  - rd_en=1, rd_addr=row_base+COL_STRIDE.
  - Set col=1; next state RUN.
- RUN, for col = 1..NUM_COLS:
  - img_shift=1 every cycle.
  - img_pad=1 only when col==NUM_COLS.
  - Read column col+1 when col+1 < NUM_COLS.
  - When col==NUM_COLS-1, rd_en=0.
  - When col==NUM_COLS and rows remain: rd_en=1 at the next row's column 0; row++; next state PRIME.
  - When col==NUM_COLS on the last row: next state DRAIN.
- Address generation:
  - rd_addr = row*ROW_STRIDE + col*COL_STRIDE.
  - Computed incrementally (row_base register plus column offset); no multiplier.
  - Wraps modulo 2^ADDR_WIDTH.
- Write path:
  - Each RUN-state img_shift enters a CORE_LAT-deep delay line.
  - The delay-line output drives wr_en.
  - wr_addr holds its value during the write cycle and advances by OUT_STEP in the cycle after each write, wrapping modulo 2^ADDR_WIDTH.
  - PRIME shifts produce no write.
- DRAIN: stay exactly CORE_LAT cycles, with the final write occurring in the last DRAIN cycle; then go to DONE.
- DONE: done=1 for 1 cycle, busy=0; then IDLE.
- Frame totals:
  - Writes: NUM_ROWS*NUM_COLS.
  - Latency from start cycle to done: 3 + NUM_ROWS*(NUM_COLS+1) + CORE_LAT cycles (41 at defaults).
- Boundary and collision cases:
  - start while busy, or in DONE: ignored.
  - abort: next cycle the state is IDLE, all strobes are 0, the delay line is cleared (no further writes) and no done pulse is issued; wr_addr keeps its value.
  - start and abort together in IDLE: abort wins.
  - rst_n low mid-frame: immediate return to reset values.

Decomposition:
- conv_pkg holds:
  - the state enum;
  - default constants COL_STRIDE, ROW_STRIDE, FILTER_ADDR, OUT_BASE, OUT_STEP, CORE_LAT;
  - the count-width localparams.
- One natural sub-module, conv_rd_addr_gen: holds the row_base and col_offset registers with clear, next-column and next-row controls, and outputs rd_addr.
- The FSM and write delay line stay in conv_seq_ctrl.

Test Plan:
1. Defaults; start pulse at cycle 0.
   - rd_addr=240 at cycle 1 and filt_load at cycle 2.
   - img_shift high in cycles 3..38 except none missing.
   - img_pad high at cycles 11, 20, 29, 38.
   - done at cycle 41.
2. Same run, write-address check.
   - 32 wr_en pulses at cycles 6..13, 15..22, 24..31 and 33..40.
   - wr_addr 384, 388, ... 508 in order.
3. Same run, read-address check.
   - Row 1 reads 135, 150, ... 240 (cols 0..7).
   - rd_en=0 in the col=7 RUN cycle of each row.
4. abort asserted at cycle 20.
   - Cycle 21: IDLE, busy=0, no wr_en afterwards, done never asserted.
   - A new start then rewrites from 384.
5. start pulses at cycles 5 and 41 (DONE) during a frame → ignored; exactly one done.
   - start with abort together in IDLE → stays IDLE.
6. rst_n low at cycle 15, released at cycle 17.
   - All outputs 0 and wr_addr=384 during reset.
   - A fresh start completes normally after release.
